// File: rtl/stream_chunk_pkg.sv
// Shared definitions for the stream chunk responder: element width codes,
// header word field positions, the end-marker constant and the FSM state type.
package stream_chunk_pkg;

    typedef enum logic [1:0] {
        WCODE_8  = 2'd0,
        WCODE_16 = 2'd1,
        WCODE_32 = 2'd2,
        WCODE_64 = 2'd3
    } width_code_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RELEASE = 2'd2
    } rsp_state_e;

    localparam int HDR_SIZE_LSB  = 0;
    localparam int HDR_SIZE_MSB  = 31;
    localparam int HDR_WIDTH_LSB = 32;
    localparam int HDR_WIDTH_MSB = 33;
    localparam int HDR_INDEX_LSB = 56;
    localparam int HDR_INDEX_MSB = 63;

    localparam logic [63:0] END_MARKER = 64'hFFFF_FFFF_FFFF_FFFF;

    // Header word returned to the engine; the index field is left zero here.
    function automatic logic [63:0] header_word(input logic [31:0] size, input width_code_e wcode);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_SIZE_MSB:HDR_SIZE_LSB]   = size;
        hdr[HDR_WIDTH_MSB:HDR_WIDTH_LSB] = wcode;
        hdr[HDR_INDEX_MSB:HDR_INDEX_LSB] = '0;
        return hdr;
    endfunction

endpackage

// File: rtl/stream_chunk_responder.sv
// Responds to stream-engine header/gather/scatter requests against an external RAM.
// Optional macro STREAM_CHUNK_BOUNDS_CHECK_EN: reject accesses with chunk_address >= SIZE.
module stream_chunk_responder
    import stream_chunk_pkg::*;
#(
    parameter int SIZE        = 1024,
    parameter int WIDTH       = 1,
    parameter int RAM_LATENCY = 1,
    localparam int ADDR_W     = $clog2(SIZE),
    localparam int DATA_W     = 8 << WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              select,
    input  logic              query_req,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [31:0]       chunk_address,
    input  logic [63:0]       write_data,
    output logic [63:0]       read_data,
    output logic              data_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic              restore_active,
    output logic              restore_done
);

    localparam logic [31:0] LAST_INDEX = 32'(SIZE - 1);
    localparam logic [2:0]  LAT_LAST   = 3'(RAM_LATENCY);

    rsp_state_e        state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic              dropped_q, dropped_d;
    logic [63:0]       read_data_d;
    logic              data_ack_d, ram_we_d, ram_re_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d;
    logic              restore_active_d, restore_done_d;
    logic              out_of_range;
    logic              unused_write_data;

    assign unused_write_data = ^write_data;

`ifdef STREAM_CHUNK_BOUNDS_CHECK_EN
    assign out_of_range = (chunk_address >= 32'(SIZE));
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d          = state_q;
        lat_cnt_d        = lat_cnt_q;
        dropped_d        = dropped_q;
        read_data_d      = read_data;
        data_ack_d       = 1'b0;
        ram_we_d         = 1'b0;
        ram_re_d         = 1'b0;
        ram_addr_d       = ram_addr;
        ram_wdata_d      = ram_wdata;
        restore_active_d = restore_active;
        restore_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (select && (read_req || write_req)) begin
                    state_d = RELEASE;
                    if (read_req) begin
                        if (query_req) begin
                            read_data_d = header_word(32'(SIZE), width_code_e'(2'(WIDTH)));
                            data_ack_d  = 1'b1;
                        end else if (out_of_range) begin
                            read_data_d = '0;
                            data_ack_d  = 1'b1;
                        end else begin
                            ram_re_d   = 1'b1;
                            ram_addr_d = chunk_address[ADDR_W-1:0];
                            lat_cnt_d  = '0;
                            dropped_d  = 1'b0;
                            state_d    = RD_WAIT;
                        end
                    end else begin
                        data_ack_d = 1'b1;
                        if (query_req) begin
                            restore_active_d = 1'b1;
                        end else begin
                            if (!out_of_range) begin
                                ram_we_d    = 1'b1;
                                ram_addr_d  = chunk_address[ADDR_W-1:0];
                                ram_wdata_d = write_data[DATA_W-1:0];
                            end
                            if (restore_active && (chunk_address == LAST_INDEX)) begin
                                restore_done_d   = 1'b1;
                                restore_active_d = 1'b0;
                            end
                        end
                    end
                end
            end

            // The strobe cycle plus RAM_LATENCY wait cycles; an engine that lets
            // go of select mid-read still lets the RAM finish but gets no ack.
            RD_WAIT: begin
                if (!select) dropped_d = 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = RELEASE;
                    if (select && !dropped_q) begin
                        read_data_d = 64'(ram_rdata);
                        data_ack_d  = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            RELEASE: begin
                if (!select || (!read_req && !write_req)) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lat_cnt_q      <= '0;
            dropped_q      <= 1'b0;
            read_data      <= '0;
            data_ack       <= 1'b0;
            ram_we         <= 1'b0;
            ram_re         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
            restore_active <= 1'b0;
            restore_done   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            dropped_q      <= dropped_d;
            read_data      <= read_data_d;
            data_ack       <= data_ack_d;
            ram_we         <= ram_we_d;
            ram_re         <= ram_re_d;
            ram_addr       <= ram_addr_d;
            ram_wdata      <= ram_wdata_d;
            restore_active <= restore_active_d;
            restore_done   <= restore_done_d;
        end
    end

endmodule

// File: tb/tb_stream_chunk_responder.sv
// Scoreboard bench for stream_chunk_responder (SIZE=1024, 16-bit elements, RAM latency 3).
`timescale 1ns/1ps
module tb_stream_chunk_responder;

    localparam int SIZE = 1024;
    localparam int LAT  = 3;

    typedef struct {
        bit          chk;
        logic [63:0] data;
    } ack_exp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } we_exp_t;

    logic        clk, reset_n, select, query_req, read_req, write_req;
    logic [31:0] chunk_address;
    logic [63:0] write_data, read_data;
    logic        data_ack, ram_we, ram_re, restore_active, restore_done;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    int tests_run = 0;
    int tests_failed = 0;
    int ack_cnt = 0, we_cnt = 0, re_cnt = 0, done_cnt = 0;
    logic [31:0] done_addr;

    ack_exp_t ack_q[$];
    we_exp_t  we_q[$];
    ack_exp_t ae;
    we_exp_t  we;

    logic [15:0] mem [1024];
    logic [15:0] pipe [1:LAT];

    stream_chunk_responder #(.SIZE(SIZE), .WIDTH(1), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .select(select), .query_req(query_req),
        .read_req(read_req), .write_req(write_req), .chunk_address(chunk_address),
        .write_data(write_data), .read_data(read_data), .data_ack(data_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_re(ram_re), .restore_active(restore_active),
        .restore_done(restore_done)
    );

    always #5 clk = ~clk;

    // External RAM: data appears LAT edges after the edge that sees ram_re.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        pipe[1] <= ram_re ? mem[ram_addr] : 16'hDEAD;
        for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata = pipe[LAT];

    // Scoreboard: every ack and RAM write must match an expectation queued by the stimulus.
    always @(negedge clk) begin
        if (reset_n) begin
            if (data_ack) begin
                ack_cnt++;
                tests_run++;
                if (ack_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_ack: unexpected data_ack, read_data=%h", read_data);
                end else begin
                    ae = ack_q.pop_front();
                    if (ae.chk && read_data !== ae.data) begin
                        tests_failed++;
                        $display("FAIL sb_read_data: got %h expected %h", read_data, ae.data);
                    end
                end
            end
            if (ram_we) begin
                we_cnt++;
                tests_run++;
                if (we_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_we: unexpected ram_we addr=%h data=%h", ram_addr, ram_wdata);
                end else begin
                    we = we_q.pop_front();
                    if (ram_addr !== we.addr || ram_wdata !== we.data) begin
                        tests_failed++;
                        $display("FAIL sb_we: got addr=%h data=%h expected addr=%h data=%h",
                                 ram_addr, ram_wdata, we.addr, we.data);
                    end
                end
            end
            if (ram_re) re_cnt++;
            if (restore_done) begin
                done_cnt++;
                done_addr = chunk_address;
            end
        end
    end

    // One request; lat = edge index (1 = sampling edge) at which data_ack showed, -1 if none.
    task automatic txn(input logic q, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wd, output int lat);
        @(negedge clk);
        select = 1'b1; query_req = q; read_req = rd; write_req = wr;
        chunk_address = addr; write_data = wd;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (data_ack) begin
                lat = i;
                break;
            end
        end
        @(negedge clk);
        query_req = 1'b0; read_req = 1'b0; write_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        tests_run++;
        if ({data_ack, ram_we, ram_re, restore_active, restore_done} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {data_ack, ram_we, ram_re, restore_active, restore_done});
        end
        tests_run++;
        if ({read_data, ram_addr, ram_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: read_data=%h ram_addr=%h ram_wdata=%h expected all 0",
                     read_data, ram_addr, ram_wdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_header_read();
        int lat;
        ack_q.push_back('{1'b1, 64'h0000_0001_0000_0400});
        txn(1'b1, 1'b1, 1'b0, 32'd0, 64'd0, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL header_latency: got %0d expected 1", lat);
        end
        tests_run++;
        if (read_data !== 64'h0000_0001_0000_0400 || data_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL header_hold: read_data=%h ack=%b expected 0000000100000400 ack=0",
                     read_data, data_ack);
        end
    endtask

    task automatic test_restore();
        int lat;
        int bad_lat = 0;
        int we0;
        ack_q.push_back('{1'b0, 64'd0});
        txn(1'b1, 1'b0, 1'b1, 32'd0, 64'd0, lat);
        tests_run++;
        if (lat !== 1 || restore_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL header_write: lat=%0d restore_active=%b expected 1 and 1", lat, restore_active);
        end
        we0 = we_cnt;
        for (int a = 0; a < SIZE; a++) begin
            ack_q.push_back('{1'b0, 64'd0});
            we_q.push_back('{a[9:0], a[15:0]});
            txn(1'b0, 1'b0, 1'b1, 32'(a), 64'(a), lat);
            if (lat != 1) bad_lat++;
        end
        tests_run++;
        if (bad_lat !== 0) begin
            tests_failed++;
            $display("FAIL restore_latency: %0d writes not acked on sampling edge, expected 0", bad_lat);
        end
        tests_run++;
        if (we_cnt - we0 !== SIZE) begin
            tests_failed++;
            $display("FAIL restore_we_count: got %0d expected %0d", we_cnt - we0, SIZE);
        end
        tests_run++;
        if (done_cnt !== 1 || done_addr !== 32'd1023) begin
            tests_failed++;
            $display("FAIL restore_done: count=%0d addr=%0d expected 1 at 1023", done_cnt, done_addr);
        end
        tests_run++;
        if (restore_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL restore_active_after: got %b expected 0", restore_active);
        end
        tests_run++;
        if (mem[512] !== 16'd512 || mem[1023] !== 16'd1023) begin
            tests_failed++;
            $display("FAIL restore_mem: mem[512]=%h mem[1023]=%h expected 0200 03ff", mem[512], mem[1023]);
        end
    endtask

    task automatic test_gather();
        int lat;
        int re0;
        ack_q.push_back('{1'b0, 64'd0});
        we_q.push_back('{10'd5, 16'hA5A5});
        txn(1'b0, 1'b0, 1'b1, 32'd5, 64'hA5A5, lat);
        re0 = re_cnt;
        ack_q.push_back('{1'b1, 64'h0000_0000_0000_A5A5});
        txn(1'b0, 1'b1, 1'b0, 32'd5, 64'd0, lat);
        // lat counts the sampling edge as 1; the ack is LAT+1 edges after it.
        tests_run++;
        if (lat - 1 !== LAT + 1) begin
            tests_failed++;
            $display("FAIL gather_latency: got %0d edges after sampling expected %0d", lat - 1, LAT + 1);
        end
        tests_run++;
        if (re_cnt - re0 !== 1) begin
            tests_failed++;
            $display("FAIL gather_re_count: got %0d expected 1", re_cnt - re0);
        end
        ack_q.push_back('{1'b1, 64'h0000_0000_0000_0064});
        txn(1'b0, 1'b1, 1'b0, 32'd100, 64'd0, lat);
        repeat (5) @(negedge clk);
        ack_q.push_back('{1'b0, 64'd0});
        we_q.push_back('{10'd6, 16'hBEEF});
        txn(1'b0, 1'b0, 1'b1, 32'd6, 64'hFFFF_0000_0000_BEEF, lat);
        tests_run++;
        if (read_data !== 64'h64) begin
            tests_failed++;
            $display("FAIL read_data_hold: got %h expected 0000000000000064", read_data);
        end
    endtask

    task automatic test_held_request();
        int ack0, we0;
        ack0 = ack_cnt; we0 = we_cnt;
        ack_q.push_back('{1'b0, 64'd0});
        we_q.push_back('{10'd7, 16'h7777});
        @(negedge clk);
        select = 1'b1; write_req = 1'b1; chunk_address = 32'd7; write_data = 64'h7777;
        repeat (10) @(posedge clk);
        @(negedge clk);
        write_req = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ack_cnt - ack0 !== 1 || we_cnt - we0 !== 1) begin
            tests_failed++;
            $display("FAIL held_request: acks=%0d writes=%0d expected 1 and 1", ack_cnt - ack0, we_cnt - we0);
        end
    endtask

    task automatic test_bounds();
        int lat;
        int we0, re0;
        we0 = we_cnt;
        ack_q.push_back('{1'b0, 64'd0});
`ifdef STREAM_CHUNK_BOUNDS_CHECK_EN
        txn(1'b0, 1'b0, 1'b1, 32'd1024, 64'h1234, lat);
        tests_run++;
        if (lat !== 1 || we_cnt - we0 !== 0) begin
            tests_failed++;
            $display("FAIL bounds_write: lat=%0d writes=%0d expected 1 and 0", lat, we_cnt - we0);
        end
        re0 = re_cnt;
        ack_q.push_back('{1'b1, 64'd0});
        txn(1'b0, 1'b1, 1'b0, 32'd2000, 64'd0, lat);
        tests_run++;
        if (lat !== 1 || re_cnt - re0 !== 0) begin
            tests_failed++;
            $display("FAIL bounds_read: lat=%0d reads=%0d expected 1 and 0", lat, re_cnt - re0);
        end
`else
        we_q.push_back('{10'd0, 16'h1234});
        txn(1'b0, 1'b0, 1'b1, 32'd1024, 64'h1234, lat);
        tests_run++;
        if (lat !== 1 || we_cnt - we0 !== 1 || mem[0] !== 16'h1234) begin
            tests_failed++;
            $display("FAIL wrap_write: lat=%0d writes=%0d mem[0]=%h expected 1 1 1234",
                     lat, we_cnt - we0, mem[0]);
        end
        re0 = re_cnt;
        ack_q.push_back('{1'b1, 64'h0000_0000_0000_A5A5});
        txn(1'b0, 1'b1, 1'b0, 32'd1029, 64'd0, lat);
        tests_run++;
        if (lat !== LAT + 2 || re_cnt - re0 !== 1) begin
            tests_failed++;
            $display("FAIL wrap_read: lat=%0d reads=%0d expected %0d and 1", lat, re_cnt - re0, LAT + 2);
        end
`endif
    endtask

    task automatic test_select_drop();
        int ack0, re0, lat;
        ack0 = ack_cnt; re0 = re_cnt;
        @(negedge clk);
        select = 1'b1; read_req = 1'b1; chunk_address = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        select = 1'b0; read_req = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (ack_cnt - ack0 !== 0 || re_cnt - re0 !== 1) begin
            tests_failed++;
            $display("FAIL select_drop: acks=%0d reads=%0d expected 0 and 1", ack_cnt - ack0, re_cnt - re0);
        end
        ack_q.push_back('{1'b1, 64'h0000_0001_0000_0400});
        txn(1'b1, 1'b1, 1'b0, 32'd0, 64'd0, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL select_drop_recover: header latency %0d expected 1", lat);
        end
    endtask

    task automatic test_reset_in_rd_wait();
        int ack0, lat;
        @(negedge clk);
        select = 1'b1; read_req = 1'b1; chunk_address = 32'd5;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({data_ack, ram_we, ram_re, restore_active, restore_done, read_data, ram_addr, ram_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: ack=%b we=%b re=%b act=%b done=%b rd=%h addr=%h wd=%h expected all 0",
                     data_ack, ram_we, ram_re, restore_active, restore_done, read_data, ram_addr, ram_wdata);
        end
        select = 1'b0; read_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ack0 = ack_cnt;
        repeat (8) @(negedge clk);
        tests_run++;
        if (ack_cnt - ack0 !== 0) begin
            tests_failed++;
            $display("FAIL reset_abandon: got %0d acks expected 0", ack_cnt - ack0);
        end
        ack_q.push_back('{1'b1, 64'h0000_0001_0000_0400});
        txn(1'b1, 1'b1, 1'b0, 32'd0, 64'd0, lat);
        tests_run++;
        if (lat !== 1 || read_data !== 64'h0000_0001_0000_0400) begin
            tests_failed++;
            $display("FAIL reset_recover: lat=%0d read_data=%h expected 1 0000000100000400", lat, read_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; reset_n = 1'b0; select = 1'b0; query_req = 1'b0;
        read_req = 1'b0; write_req = 1'b0; chunk_address = '0; write_data = '0;
        test_reset();
        test_header_read();
        test_restore();
        test_gather();
        test_held_request();
        test_bounds();
        test_select_drop();
        test_reset_in_rd_wait();
        repeat (2) @(negedge clk);
        tests_run++;
        if (ack_q.size() !== 0 || we_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d acks and %0d writes never seen, expected 0 and 0",
                     ack_q.size(), we_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_chunk_responder.md
STREAM_CHUNK_RESPONDER -- requirements
Module: stream_chunk_responder

Interface
REQ-001 SHALL have parameter SIZE, default 1024, meaning chunk element count (1..2^20).
REQ-002 SHALL have parameter WIDTH, default 1, meaning element width code (0=8b, 1=16b, 2=32b, 3=64b).
REQ-003 SHALL have parameter RAM_LATENCY, default 1, meaning local RAM read latency in cycles (1..4).
REQ-004 SHALL derive localparams ADDR_W=$clog2(SIZE) and DATA_W=8<<WIDTH.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock.
- reset_n  in  1  reset, asynchronous, active-low.
- select  in  1  this responder addressed by the stream engine.
- query_req  in  1  header transaction.
- read_req  in  1  gather (save) request.
- write_req  in  1  scatter (restore) request.
- chunk_address  in  32  element index.
- write_data  in  64  restore element, LSB-aligned.
- read_data  out  64  header or element, LSB-aligned, upper bits zero.
- data_ack  out  1  one-cycle acknowledge.
- ram_addr  out  ADDR_W  local RAM address.
- ram_wdata  out  DATA_W  local RAM write data.
- ram_rdata  in  DATA_W  local RAM read data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- restore_active  out  1  restore in progress.
- restore_done  out  1  one-cycle pulse when the last element is written.

Function
REQ-006 SHALL implement FSM states IDLE, RD_WAIT, RELEASE.
REQ-007 SHALL, in IDLE with select=1 and read_req or write_req high, start exactly one transaction; read_req has priority when both are high.
REQ-008 SHALL answer header read (query_req & read_req): read_data={30'b0, WIDTH[1:0], SIZE[31:0]}, with data_ack high on the next edge; next state RELEASE.
REQ-009 SHALL answer header write (query_req & write_req): data_ack on the next edge, set restore_active=1, no RAM access; next state RELEASE.
REQ-010 SHALL handle data write (write_req, no query): ram_we=1, ram_addr=chunk_address[ADDR_W-1:0], ram_wdata=write_data[DATA_W-1:0], and data_ack, all in the same registered cycle; next state RELEASE.
REQ-011 SHALL handle data read (read_req, no query):
- ram_re=1 for one cycle, then RD_WAIT for RAM_LATENCY cycles.
- Then latch ram_rdata zero-extended into read_data and pulse data_ack.
- Total latency RAM_LATENCY+1 edges from the sampling edge.
REQ-012 SHALL hold data_ack, ram_we and ram_re high for exactly one cycle per transaction.
REQ-013 SHALL remain in RELEASE until read_req=0 and write_req=0 (or select=0), then return to IDLE; no re-acknowledge of a held request.
REQ-014 SHALL hold read_data stable from data_ack until the next transaction latches new data.
REQ-015 SHALL pulse restore_done and clear restore_active on the edge acknowledging a data write with chunk_address==SIZE-1 while restore_active=1.
REQ-016 SHALL, if select falls during RD_WAIT, complete the RAM read, suppress data_ack, and go to RELEASE.
REQ-017 SHALL answer header queries within 1 cycle, meeting the engine's 16-cycle query timeout.

Reset
REQ-018 SHALL, on reset_n=0 (asynchronous), enter IDLE with data_ack, ram_we, ram_re, restore_active, restore_done=0, and read_data, ram_addr, ram_wdata=0.
REQ-019 SHALL abandon any in-flight transaction on reset with no ack; reset release is synchronous to clk.

Configuration
REQ-020 SHALL, with STREAM_CHUNK_BOUNDS_CHECK_EN defined, treat accesses with chunk_address>=SIZE as follows:
- writes: acknowledged, no ram_we.
- reads: acknowledged after 1 cycle with read_data=0, no ram_re.
REQ-021 SHALL, without STREAM_CHUNK_BOUNDS_CHECK_EN, truncate chunk_address to ADDR_W bits (wrap) for all accesses.

Structure
REQ-022 SHALL place the width-code enum, header field positions (SIZE [31:0], WIDTH [33:32], index [63:56]) and the end-marker constant (all ones) in shared package stream_chunk_pkg.
REQ-023 SHALL have no sub-module; the RAM stays external and the latency counter is inline.

Verification
REQ-024 Header read: SIZE=1024, WIDTH=1; select, query_req, read_req -> next edge read_data=64'h0000_0001_0000_0400, data_ack for one cycle.
REQ-025 Restore: header write, then 1024 write_req pulses with addr 0..1023 and data=addr -> 1024 ram_we; restore_done on addr 1023; restore_active low afterwards.
REQ-026 Gather, RAM_LATENCY=3, RAM preloaded with 16'hA5A5 at addr 5: read_req at addr 5 -> data_ack 4 edges later, read_data=64'hA5A5.
REQ-027 Held request: write_req held for 10 cycles -> exactly one data_ack and one ram_we.
REQ-028 Bounds: addr 1024 write, with the macro -> ack and no ram_we; without the macro -> ram_we with ram_addr=0.
REQ-029 Reset: reset_n pulsed low during RD_WAIT -> no data_ack, all outputs 0, FSM in IDLE; a subsequent header read succeeds.
